// File: rtl/cr_had_dbgreq_ctrl.sv
// cr_had_dbgreq_ctrl: debug-entry request controller between the breakpoint
// unit / HAD register file and the IU debug interface. Arbitrates halt and
// breakpoint requests, raises the debug-mode request to the core, waits for
// the ack with a timeout, tracks the debug exit handshake and records the
// entry cause.
// Optional feature: define CR_HAD_BKPT_HIT_CNT_EN to enable the breakpoint
// hit-skip counter (breakpoint requests are dropped while it is non-zero).
module cr_had_dbgreq_ctrl #(
    parameter int unsigned ACK_TMO_CYC = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             cpuclk,
    input  logic             hadrst,
    input  logic             regs_ctrl_dr,
    input  logic             regs_ctrl_exit,
    input  logic             bkpt_ctrl_req,
    input  logic             bkpt_ctrl_inst_fetch_dbq_req,
    input  logic             iu_yy_xx_dbgon,
    input  logic             regs_bkpt_cnt_wr,
    input  logic [CNT_W-1:0] regs_bkpt_cnt,
    output logic             had_core_dbg_mode_req,
    output logic             had_core_exit_dbg_req,
    output logic [2:0]       had_regs_dbg_cause,
    output logic             had_regs_ack_tmo,
    output logic [CNT_W-1:0] had_regs_bkpt_cnt_cur
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_DBG,
        ST_EXIT
    } state_t;

    localparam logic [2:0] CAUSE_HALT = 3'd1;
    localparam logic [2:0] CAUSE_DBKP = 3'd2;
    localparam logic [2:0] CAUSE_IBKP = 3'd3;
    localparam logic [7:0] TMO_LAST   = 8'(ACK_TMO_CYC - 1);

    state_t     state_q, state_d;
    logic       req_q, req_d;
    logic       exit_q, exit_d;
    logic [2:0] cause_q, cause_d;
    logic       tmo_q, tmo_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    logic       bkpt_any;
    logic [2:0] bkpt_code;
    logic       bkpt_ok;
    logic       bkpt_skip;

    // Breakpoint source selection: data breakpoint outranks instruction breakpoint
    always_comb begin
        bkpt_any  = bkpt_ctrl_req | bkpt_ctrl_inst_fetch_dbq_req;
        bkpt_code = bkpt_ctrl_req ? CAUSE_DBKP : CAUSE_IBKP;
    end

`ifdef CR_HAD_BKPT_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Hit-skip counter: a load beats a decrement; decrement saturates at zero
    always_comb begin
        bkpt_ok = (cnt_q == '0);
        cnt_d   = cnt_q;
        if (regs_bkpt_cnt_wr) begin
            cnt_d = regs_bkpt_cnt;
        end else if (bkpt_skip && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Hit-skip counter register
    always_ff @(posedge cpuclk) begin
        if (hadrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign had_regs_bkpt_cnt_cur = cnt_q;
`else
    logic unused_cnt_in;

    // Counter absent: every breakpoint request is eligible, load ports unused
    always_comb begin
        bkpt_ok       = 1'b1;
        unused_cnt_in = regs_bkpt_cnt_wr ^ (^regs_bkpt_cnt) ^ bkpt_skip;
    end

    assign had_regs_bkpt_cnt_cur = '0;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        exit_d    = exit_q;
        cause_d   = cause_q;
        tmo_d     = tmo_q;
        tmo_cnt_d = tmo_cnt_q;
        bkpt_skip = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_d  = 1'b0;
                exit_d = 1'b0;
                if (iu_yy_xx_dbgon) begin
                    // core entered debug by another path; cause left as is
                    state_d = ST_DBG;
                end else if (regs_ctrl_dr) begin
                    state_d   = ST_WAIT_ACK;
                    req_d     = 1'b1;
                    cause_d   = CAUSE_HALT;
                    tmo_cnt_d = '0;
                end else if (bkpt_any) begin
                    if (bkpt_ok) begin
                        state_d   = ST_WAIT_ACK;
                        req_d     = 1'b1;
                        cause_d   = bkpt_code;
                        tmo_cnt_d = '0;
                    end else begin
                        bkpt_skip = 1'b1;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (iu_yy_xx_dbgon) begin
                    state_d = ST_DBG;
                    req_d   = 1'b0;
                    tmo_d   = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_DBG: begin
                if (regs_ctrl_exit) begin
                    state_d = ST_EXIT;
                    exit_d  = 1'b1;
                end
            end
            ST_EXIT: begin
                if (!iu_yy_xx_dbgon) begin
                    state_d = ST_IDLE;
                    exit_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                exit_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge cpuclk) begin
        if (hadrst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            exit_q    <= 1'b0;
            cause_q   <= '0;
            tmo_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            exit_q    <= exit_d;
            cause_q   <= cause_d;
            tmo_q     <= tmo_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign had_core_dbg_mode_req = req_q;
    assign had_core_exit_dbg_req = exit_q;
    assign had_regs_dbg_cause    = cause_q;
    assign had_regs_ack_tmo      = tmo_q;

endmodule

// File: tb/tb_cr_had_dbgreq_ctrl.sv
// Directed bench for cr_had_dbgreq_ctrl. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, i.e. just after each update.
module tb_cr_had_dbgreq_ctrl;

    logic       cpuclk;
    logic       hadrst;
    logic       regs_ctrl_dr;
    logic       regs_ctrl_exit;
    logic       bkpt_ctrl_req;
    logic       bkpt_ctrl_inst_fetch_dbq_req;
    logic       iu_yy_xx_dbgon;
    logic       regs_bkpt_cnt_wr;
    logic [7:0] regs_bkpt_cnt;
    logic       had_core_dbg_mode_req;
    logic       had_core_exit_dbg_req;
    logic [2:0] had_regs_dbg_cause;
    logic       had_regs_ack_tmo;
    logic [7:0] had_regs_bkpt_cnt_cur;

    int passed;
    int total;

    cr_had_dbgreq_ctrl #(.ACK_TMO_CYC(16), .CNT_W(8)) dut (
        .cpuclk                       (cpuclk),
        .hadrst                       (hadrst),
        .regs_ctrl_dr                 (regs_ctrl_dr),
        .regs_ctrl_exit               (regs_ctrl_exit),
        .bkpt_ctrl_req                (bkpt_ctrl_req),
        .bkpt_ctrl_inst_fetch_dbq_req (bkpt_ctrl_inst_fetch_dbq_req),
        .iu_yy_xx_dbgon               (iu_yy_xx_dbgon),
        .regs_bkpt_cnt_wr             (regs_bkpt_cnt_wr),
        .regs_bkpt_cnt                (regs_bkpt_cnt),
        .had_core_dbg_mode_req        (had_core_dbg_mode_req),
        .had_core_exit_dbg_req        (had_core_exit_dbg_req),
        .had_regs_dbg_cause           (had_regs_dbg_cause),
        .had_regs_ack_tmo             (had_regs_ack_tmo),
        .had_regs_bkpt_cnt_cur        (had_regs_bkpt_cnt_cur)
    );

    initial cpuclk = 1'b0;
    always #5 cpuclk = ~cpuclk;

    task automatic tick();
        @(posedge cpuclk);
        #1;
    endtask

    // From DBG: pulse exit, then drop dbgon so the FSM returns to IDLE
    task automatic leave_dbg();
        regs_ctrl_exit = 1'b1;
        tick();
        regs_ctrl_exit = 1'b0;
        iu_yy_xx_dbgon = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        hadrst = 1'b1;
        tick();
        tick();
        total++; if (had_core_dbg_mode_req !== 1'b0) $display("FAIL rst_req: got %0d expected 0", had_core_dbg_mode_req); else passed++;
        total++; if (had_core_exit_dbg_req !== 1'b0) $display("FAIL rst_exit: got %0d expected 0", had_core_exit_dbg_req); else passed++;
        total++; if (had_regs_dbg_cause !== 3'd0) $display("FAIL rst_cause: got %0d expected 0", had_regs_dbg_cause); else passed++;
        total++; if (had_regs_ack_tmo !== 1'b0) $display("FAIL rst_tmo: got %0d expected 0", had_regs_ack_tmo); else passed++;
        total++; if (had_regs_bkpt_cnt_cur !== 8'd0) $display("FAIL rst_cnt: got %0d expected 0", had_regs_bkpt_cnt_cur); else passed++;
        hadrst = 1'b0;
        tick();
    endtask

    task automatic test_bkpt_ack();
        int hi;
        bkpt_ctrl_req = 1'b1;
        tick();
        bkpt_ctrl_req = 1'b0;
        total++; if (had_regs_dbg_cause !== 3'd2) $display("FAIL bkpt_cause: got %0d expected 2", had_regs_dbg_cause); else passed++;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (had_core_dbg_mode_req === 1'b1) hi++;
            if (i == 2) iu_yy_xx_dbgon = 1'b1;
            tick();
        end
        total++; if (hi !== 3) $display("FAIL bkpt_req_len: got %0d expected 3", hi); else passed++;
        total++; if (had_core_dbg_mode_req !== 1'b0) $display("FAIL bkpt_req_drop: got %0d expected 0", had_core_dbg_mode_req); else passed++;
    endtask

    task automatic test_exit();
        bkpt_ctrl_req = 1'b1;
        bkpt_ctrl_inst_fetch_dbq_req = 1'b1;
        tick();
        bkpt_ctrl_req = 1'b0;
        bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
        total++; if (had_core_dbg_mode_req !== 1'b0) $display("FAIL dbg_ignore_req: got %0d expected 0", had_core_dbg_mode_req); else passed++;
        total++; if (had_regs_dbg_cause !== 3'd2) $display("FAIL dbg_ignore_cause: got %0d expected 2", had_regs_dbg_cause); else passed++;
        regs_ctrl_exit = 1'b1;
        tick();
        regs_ctrl_exit = 1'b0;
        total++; if (had_core_exit_dbg_req !== 1'b1) $display("FAIL exit_rise: got %0d expected 1", had_core_exit_dbg_req); else passed++;
        tick();
        tick();
        total++; if (had_core_exit_dbg_req !== 1'b1) $display("FAIL exit_hold: got %0d expected 1", had_core_exit_dbg_req); else passed++;
        iu_yy_xx_dbgon = 1'b0;
        tick();
        total++; if (had_core_exit_dbg_req !== 1'b0) $display("FAIL exit_fall: got %0d expected 0", had_core_exit_dbg_req); else passed++;
        tick();
        total++; if (had_core_dbg_mode_req !== 1'b0) $display("FAIL exit_no_queue: got %0d expected 0", had_core_dbg_mode_req); else passed++;
    endtask

    task automatic test_priority();
        regs_ctrl_dr = 1'b1;
        bkpt_ctrl_req = 1'b1;
        bkpt_ctrl_inst_fetch_dbq_req = 1'b1;
        tick();
        regs_ctrl_dr = 1'b0;
        bkpt_ctrl_req = 1'b0;
        bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
        total++; if (had_core_dbg_mode_req !== 1'b1) $display("FAIL prio_req: got %0d expected 1", had_core_dbg_mode_req); else passed++;
        total++; if (had_regs_dbg_cause !== 3'd1) $display("FAIL prio_cause: got %0d expected 1", had_regs_dbg_cause); else passed++;
        iu_yy_xx_dbgon = 1'b1;
        tick();
        total++; if (had_core_dbg_mode_req !== 1'b0) $display("FAIL prio_ack: got %0d expected 0", had_core_dbg_mode_req); else passed++;
        leave_dbg();
        tick();
        total++; if (had_core_dbg_mode_req !== 1'b0) $display("FAIL prio_dropped: got %0d expected 0", had_core_dbg_mode_req); else passed++;
        total++; if (had_regs_dbg_cause !== 3'd1) $display("FAIL prio_cause_hold: got %0d expected 1", had_regs_dbg_cause); else passed++;
    endtask

    task automatic test_timeout();
        int hi;
        bkpt_ctrl_inst_fetch_dbq_req = 1'b1;
        tick();
        bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
        hi = (had_core_dbg_mode_req === 1'b1) ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (had_core_dbg_mode_req === 1'b1) hi++;
        end
        total++; if (hi !== 16) $display("FAIL tmo_req_len: got %0d expected 16", hi); else passed++;
        total++; if (had_regs_ack_tmo !== 1'b1) $display("FAIL tmo_flag: got %0d expected 1", had_regs_ack_tmo); else passed++;
        total++; if (had_regs_dbg_cause !== 3'd3) $display("FAIL tmo_cause: got %0d expected 3", had_regs_dbg_cause); else passed++;
        bkpt_ctrl_req = 1'b1;
        tick();
        bkpt_ctrl_req = 1'b0;
        total++; if (had_core_dbg_mode_req !== 1'b1) $display("FAIL tmo_idle_req: got %0d expected 1", had_core_dbg_mode_req); else passed++;
        total++; if (had_regs_ack_tmo !== 1'b1) $display("FAIL tmo_sticky: got %0d expected 1", had_regs_ack_tmo); else passed++;
        iu_yy_xx_dbgon = 1'b1;
        tick();
        total++; if (had_regs_ack_tmo !== 1'b0) $display("FAIL tmo_clear: got %0d expected 0", had_regs_ack_tmo); else passed++;
    endtask

    task automatic test_reentry();
        regs_ctrl_dr = 1'b1;
        regs_ctrl_exit = 1'b1;
        tick();
        regs_ctrl_exit = 1'b0;
        total++; if (had_core_exit_dbg_req !== 1'b1) $display("FAIL reent_exit: got %0d expected 1", had_core_exit_dbg_req); else passed++;
        total++; if (had_core_dbg_mode_req !== 1'b0) $display("FAIL reent_dbg_ignore: got %0d expected 0", had_core_dbg_mode_req); else passed++;
        iu_yy_xx_dbgon = 1'b0;
        tick();
        total++; if (had_core_exit_dbg_req !== 1'b0) $display("FAIL reent_exit_fall: got %0d expected 0", had_core_exit_dbg_req); else passed++;
        tick();
        total++; if (had_core_dbg_mode_req !== 1'b1) $display("FAIL reent_req: got %0d expected 1", had_core_dbg_mode_req); else passed++;
        total++; if (had_regs_dbg_cause !== 3'd1) $display("FAIL reent_cause: got %0d expected 1", had_regs_dbg_cause); else passed++;
        regs_ctrl_dr = 1'b0;
        iu_yy_xx_dbgon = 1'b1;
        tick();
        leave_dbg();
    endtask

    task automatic test_external_dbg();
        iu_yy_xx_dbgon = 1'b1;
        tick();
        total++; if (had_core_dbg_mode_req !== 1'b0) $display("FAIL ext_req: got %0d expected 0", had_core_dbg_mode_req); else passed++;
        total++; if (had_regs_dbg_cause !== 3'd1) $display("FAIL ext_cause: got %0d expected 1", had_regs_dbg_cause); else passed++;
        regs_ctrl_exit = 1'b1;
        tick();
        regs_ctrl_exit = 1'b0;
        total++; if (had_core_exit_dbg_req !== 1'b1) $display("FAIL ext_exit: got %0d expected 1", had_core_exit_dbg_req); else passed++;
        iu_yy_xx_dbgon = 1'b0;
        tick();
        total++; if (had_core_exit_dbg_req !== 1'b0) $display("FAIL ext_exit_fall: got %0d expected 0", had_core_exit_dbg_req); else passed++;
    endtask

    task automatic test_hit_cnt();
`ifdef CR_HAD_BKPT_HIT_CNT_EN
        logic [7:0] exp_cnt [3];
        logic       exp_req [3];
        exp_cnt[0] = 8'd1; exp_req[0] = 1'b0;
        exp_cnt[1] = 8'd0; exp_req[1] = 1'b0;
        exp_cnt[2] = 8'd0; exp_req[2] = 1'b1;
        regs_bkpt_cnt = 8'd2;
        regs_bkpt_cnt_wr = 1'b1;
        tick();
        regs_bkpt_cnt_wr = 1'b0;
        total++; if (had_regs_bkpt_cnt_cur !== 8'd2) $display("FAIL cnt_load: got %0d expected 2", had_regs_bkpt_cnt_cur); else passed++;
        for (int i = 0; i < 3; i++) begin
            bkpt_ctrl_inst_fetch_dbq_req = 1'b1;
            tick();
            bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
            total++; if (had_regs_bkpt_cnt_cur !== exp_cnt[i]) $display("FAIL cnt_val%0d: got %0d expected %0d", i, had_regs_bkpt_cnt_cur, exp_cnt[i]); else passed++;
            total++; if (had_core_dbg_mode_req !== exp_req[i]) $display("FAIL cnt_req%0d: got %0d expected %0d", i, had_core_dbg_mode_req, exp_req[i]); else passed++;
        end
        total++; if (had_regs_dbg_cause !== 3'd3) $display("FAIL cnt_cause: got %0d expected 3", had_regs_dbg_cause); else passed++;
`else
        regs_bkpt_cnt = 8'd5;
        regs_bkpt_cnt_wr = 1'b1;
        tick();
        regs_bkpt_cnt_wr = 1'b0;
        total++; if (had_regs_bkpt_cnt_cur !== 8'd0) $display("FAIL nocnt_val: got %0d expected 0", had_regs_bkpt_cnt_cur); else passed++;
        bkpt_ctrl_inst_fetch_dbq_req = 1'b1;
        tick();
        bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
        total++; if (had_core_dbg_mode_req !== 1'b1) $display("FAIL nocnt_req: got %0d expected 1", had_core_dbg_mode_req); else passed++;
        total++; if (had_regs_dbg_cause !== 3'd3) $display("FAIL nocnt_cause: got %0d expected 3", had_regs_dbg_cause); else passed++;
`endif
        iu_yy_xx_dbgon = 1'b1;
        tick();
        leave_dbg();
    endtask

    task automatic test_reset_mid();
        regs_ctrl_dr = 1'b1;
        tick();
        regs_ctrl_dr = 1'b0;
        total++; if (had_core_dbg_mode_req !== 1'b1) $display("FAIL rmid_req_pre: got %0d expected 1", had_core_dbg_mode_req); else passed++;
        hadrst = 1'b1;
        tick();
        total++; if (had_core_dbg_mode_req !== 1'b0) $display("FAIL rmid_req: got %0d expected 0", had_core_dbg_mode_req); else passed++;
        total++; if (had_regs_dbg_cause !== 3'd0) $display("FAIL rmid_cause: got %0d expected 0", had_regs_dbg_cause); else passed++;
        total++; if (had_core_exit_dbg_req !== 1'b0) $display("FAIL rmid_exit: got %0d expected 0", had_core_exit_dbg_req); else passed++;
        total++; if (had_regs_ack_tmo !== 1'b0) $display("FAIL rmid_tmo: got %0d expected 0", had_regs_ack_tmo); else passed++;
        hadrst = 1'b0;
        tick();
        tick();
        total++; if (had_core_dbg_mode_req !== 1'b0) $display("FAIL rmid_idle: got %0d expected 0", had_core_dbg_mode_req); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        passed = 0;
        total  = 0;
        hadrst = 1'b1;
        regs_ctrl_dr = 1'b0;
        regs_ctrl_exit = 1'b0;
        bkpt_ctrl_req = 1'b0;
        bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
        iu_yy_xx_dbgon = 1'b0;
        regs_bkpt_cnt_wr = 1'b0;
        regs_bkpt_cnt = 8'd0;

        test_reset();
        test_bkpt_ack();
        test_exit();
        test_priority();
        test_timeout();
        test_reentry();
        test_external_dbg();
        test_hit_cnt();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
